// File: rtl/c1541_pkg.sv
// C1541 track controller shared types and helpers.
// Zone geometry of a 35-track D64 image.
package c1541_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_WB_SCAN,
    S_WB_REQ,
    S_WB_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_READY
  } state_t;

  localparam int MAX_SPT = 21;

  function automatic logic [5:0] clamp_track(input logic [5:0] t);
    if (t == 6'd0) return 6'd1;
    if (t > 6'd35) return 6'd35;
    return t;
  endfunction

  function automatic logic [4:0] spt(input logic [5:0] t);
    logic [5:0] c;
    c = clamp_track(t);
    if (c <= 6'd17) return 5'd21;
    if (c <= 6'd24) return 5'd19;
    if (c <= 6'd30) return 5'd18;
    return 5'd17;
  endfunction

  function automatic logic [9:0] track_base(input logic [5:0] t);
    logic [9:0] c;
    c = {4'd0, clamp_track(t)};
    if (c <= 10'd17) return (c - 10'd1) * 10'd21;
    if (c <= 10'd24) return 10'd357 + (c - 10'd18) * 10'd19;
    if (c <= 10'd30) return 10'd490 + (c - 10'd25) * 10'd18;
    return 10'd598 + (c - 10'd31) * 10'd17;
  endfunction

endpackage

// File: rtl/c1541_track_lba.sv
// D64 sector index of a (track, sector) pair.
// Track 0 maps to track 1 so an empty slot yields LBA 0.
module c1541_track_lba
  import c1541_pkg::*;
(
  input  logic [5:0]  track,
  input  logic [4:0]  sector,
  output logic [31:0] lba
);

  assign lba = {22'd0, track_base(track)} + {27'd0, sector};

endmodule

// File: rtl/c1541_track_ctl.sv
// Track buffer controller: settles head moves, writes back
// dirty sectors, then streams the new track in from SD.
module c1541_track_ctl
  import c1541_pkg::*;
#(
  parameter int SETTLE = 1024
) (
  input  logic        clk32,
  input  logic        reset_n,
  input  logic [5:0]  track,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        gcr_we,
  input  logic [4:0]  gcr_sector,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_done,
  output logic [4:0]  buf_sector,
  output logic [5:0]  loaded_track,
  output logic        ram_ready
);

  localparam int CW = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0] SMAX = CW'(SETTLE - 1);

  state_t state, state_n;

  logic [MAX_SPT-1:0] dirty;
  logic               pending;
  logic [CW-1:0]      cnt;
  logic [5:0]         cand;
  logic [5:0]         target;

  logic [5:0] tclamp;
  logic [4:0] spt_l;
  logic [4:0] spt_t;
  logic       go;
  logic       brk;
  logic       last;
  logic       found;
  logic [4:0] idx;
  logic       wb_phase;
  logic [5:0] lba_trk;

  assign tclamp = clamp_track(track);
  assign spt_l  = spt(loaded_track);
  assign spt_t  = spt(target);
  assign go     = (tclamp != loaded_track) | pending | img_mounted;
  assign brk    = (tclamp != target) | pending | img_mounted;
  assign last   = (buf_sector == spt_t - 5'd1);

  assign sd_wr = (state == S_WB_REQ);
  assign sd_rd = (state == S_RD_REQ);

  assign wb_phase = (state == S_WB_SCAN) | (state == S_WB_REQ) |
                    (state == S_WB_WAIT);
  assign lba_trk  = wb_phase ? loaded_track : target;

  c1541_track_lba u_lba (
    .track  (lba_trk),
    .sector (buf_sector),
    .lba    (sd_lba)
  );

  // Lowest dirty sector of the buffered track.
  always_comb begin
    found = 1'b0;
    idx   = 5'd0;
    for (int i = MAX_SPT - 1; i >= 0; i--) begin
      if (dirty[i]) begin
        found = 1'b1;
        idx   = i[4:0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (go) state_n = S_SETTLE;
      S_READY:   if (go) state_n = S_SETTLE;
      S_SETTLE:
        if (tclamp == cand && cnt == SMAX) state_n = S_WB_SCAN;
      S_WB_SCAN: state_n = found ? S_WB_REQ : S_RD_REQ;
      S_WB_REQ:  if (sd_ack) state_n = S_WB_WAIT;
      S_WB_WAIT:
        if (sd_done) state_n = brk ? S_SETTLE : S_WB_SCAN;
      S_RD_REQ:  if (sd_ack) state_n = S_RD_WAIT;
      S_RD_WAIT:
        if (sd_done) begin
          if (brk)       state_n = S_SETTLE;
          else if (last) state_n = S_READY;
          else           state_n = S_RD_REQ;
        end
      default:   state_n = S_IDLE;
    endcase
  end

  // State register and datapath updates.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      ram_ready    <= 1'b0;
      dirty        <= '0;
      pending      <= 1'b0;
      cnt          <= '0;
      cand         <= 6'd0;
      target       <= 6'd0;
      buf_sector   <= 5'd0;
      loaded_track <= 6'd0;
    end else begin
      state     <= state_n;
      ram_ready <= (state_n == S_READY);

      if (state != S_SETTLE && state_n == S_SETTLE) begin
        cnt  <= '0;
        cand <= tclamp;
      end else if (state == S_SETTLE) begin
        if (tclamp != cand) begin
          cnt  <= '0;
          cand <= tclamp;
        end else if (cnt != SMAX) begin
          cnt <= cnt + 1'b1;
        end
      end

      if (state == S_SETTLE && state_n == S_WB_SCAN) begin
        target  <= cand;
        pending <= 1'b0;
      end

      if (state == S_WB_SCAN)
        buf_sector <= found ? idx : 5'd0;

      if (state == S_WB_WAIT && sd_done)
        dirty[buf_sector] <= 1'b0;

      if (state == S_RD_REQ)
        loaded_track <= target;

      if (state == S_RD_WAIT && sd_done) begin
        if (brk)
          loaded_track <= 6'd0;
        else if (!last)
          buf_sector <= buf_sector + 5'd1;
      end

      if (state == S_READY && gcr_we && !img_readonly &&
          gcr_sector < spt_l)
        dirty[gcr_sector] <= 1'b1;

      if (img_mounted) begin
        dirty   <= '0;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_c1541_track_ctl.sv
// Bench for c1541_track_ctl: track loads, writeback,
// read-only, clamping, mid-load track change and remount.
module tb_c1541_track_ctl;

  localparam int SETTLE = 8;

  logic        clk32 = 1'b0;
  logic        reset_n;
  logic [5:0]  track;
  logic        img_mounted;
  logic        img_readonly;
  logic        gcr_we;
  logic [4:0]  gcr_sector;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        sd_done;
  logic [4:0]  buf_sector;
  logic [5:0]  loaded_track;
  logic        ram_ready;

  always #5 clk32 = ~clk32;

  c1541_track_ctl #(.SETTLE(SETTLE)) dut (
    .clk32        (clk32),
    .reset_n      (reset_n),
    .track        (track),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .gcr_we       (gcr_we),
    .gcr_sector   (gcr_sector),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_done      (sd_done),
    .buf_sector   (buf_sector),
    .loaded_track (loaded_track),
    .ram_ready    (ram_ready)
  );

  int n_pass  = 0;
  int n_total = 0;

  bit          log_wr[$];
  logic [31:0] log_lba[$];
  bit          exp_wr[$];
  logic [31:0] exp_lba[$];
  bit          both_seen = 1'b0;

  typedef struct {
    logic [5:0] trk;
    logic [5:0] exp_loaded;
    int         exp_base;
    int         exp_n;
  } vec_t;

  vec_t vecs[9];

  // SD responder: ack one cycle after a request, done later.
  initial begin
    sd_ack  = 1'b0;
    sd_done = 1'b0;
    forever begin
      @(negedge clk32);
      if (reset_n && (sd_rd || sd_wr)) begin
        @(negedge clk32);
        log_wr.push_back(sd_wr);
        log_lba.push_back(sd_lba);
        sd_ack = 1'b1;
        @(negedge clk32);
        sd_ack = 1'b0;
        repeat (2) @(negedge clk32);
        sd_done = 1'b1;
        @(negedge clk32);
        sd_done = 1'b0;
      end
    end
  end

  always @(negedge clk32)
    if (sd_rd && sd_wr) both_seen = 1'b1;

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic clear_logs();
    log_wr.delete();
    log_lba.delete();
    exp_wr.delete();
    exp_lba.delete();
  endtask

  task automatic exp_reads(int first, int n);
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back(1'b0);
      exp_lba.push_back(32'(first + i));
    end
  endtask

  task automatic exp_write(int lba);
    exp_wr.push_back(1'b1);
    exp_lba.push_back(32'(lba));
  endtask

  task automatic cmp_log(string name);
    int bad;
    int n;
    bad = 0;
    n = (log_lba.size() < exp_lba.size()) ? log_lba.size()
                                          : exp_lba.size();
    check({name, "_len"}, log_lba.size(), exp_lba.size());
    for (int i = 0; i < n; i++)
      if (log_wr[i] !== exp_wr[i] || log_lba[i] !== exp_lba[i])
        bad++;
    check({name, "_seq_errs"}, bad, 0);
  endtask

  task automatic wait_ready(string name);
    int k;
    k = 0;
    while (ram_ready !== 1'b1 && k < 3000) begin
      @(negedge clk32);
      k++;
    end
    check({name, "_ready"}, ram_ready, 1);
  endtask

  task automatic load(string name, logic [5:0] t);
    track = t;
    @(negedge clk32);
    check({name, "_drop"}, ram_ready, 0);
    wait_ready(name);
  endtask

  task automatic gcr(logic [4:0] sec);
    gcr_sector = sec;
    gcr_we = 1'b1;
    @(negedge clk32);
    gcr_we = 1'b0;
  endtask

  initial begin
    vecs[0] = '{6'd18, 6'd18, 357, 19};
    vecs[1] = '{6'd35, 6'd35, 666, 17};
    vecs[2] = '{6'd0,  6'd1,  0,   21};
    vecs[3] = '{6'd40, 6'd35, 666, 17};
    vecs[4] = '{6'd24, 6'd24, 471, 19};
    vecs[5] = '{6'd25, 6'd25, 490, 18};
    vecs[6] = '{6'd30, 6'd30, 580, 18};
    vecs[7] = '{6'd31, 6'd31, 598, 17};
    vecs[8] = '{6'd17, 6'd17, 336, 21};

    reset_n      = 1'b0;
    track        = 6'd18;
    img_mounted  = 1'b0;
    img_readonly = 1'b0;
    gcr_we       = 1'b0;
    gcr_sector   = 5'd0;
    repeat (3) @(negedge clk32);
    check("rst_lba", sd_lba, 0);
    check("rst_rd", sd_rd, 0);
    check("rst_wr", sd_wr, 0);
    check("rst_ready", ram_ready, 0);
    check("rst_loaded", loaded_track, 0);
    check("rst_bufsec", buf_sector, 0);
    reset_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      clear_logs();
      load($sformatf("vec%0d", v), vecs[v].trk);
      exp_reads(vecs[v].exp_base, vecs[v].exp_n);
      cmp_log($sformatf("vec%0d", v));
      check($sformatf("vec%0d_loaded", v), loaded_track,
            vecs[v].exp_loaded);
    end

    // Dirty writeback on track 1 before moving to track 2.
    clear_logs();
    load("t1", 6'd1);
    clear_logs();
    gcr(5'd3);
    gcr(5'd20);
    load("wb", 6'd2);
    exp_write(3);
    exp_write(20);
    exp_reads(21, 21);
    cmp_log("wb");
    check("wb_loaded", loaded_track, 2);

    // Read-only image never marks sectors dirty.
    clear_logs();
    img_readonly = 1'b1;
    gcr(5'd5);
    img_readonly = 1'b0;
    load("ro", 6'd3);
    exp_reads(42, 21);
    cmp_log("ro");

    // Track change while sector 4 of track 10 is in flight.
    begin
      int k;
      clear_logs();
      track = 6'd10;
      k = 0;
      while (log_lba.size() < 5 && k < 2000) begin
        @(negedge clk32);
        k++;
      end
      check("mid_reach_s4", log_lba.size(), 5);
      track = 6'd12;
      repeat (6) @(negedge clk32);
      check("mid_partial_loaded", loaded_track, 0);
      check("mid_ready_low", ram_ready, 0);
      wait_ready("mid");
      exp_reads(189, 5);
      exp_reads(231, 21);
      cmp_log("mid");
      check("mid_loaded", loaded_track, 12);
    end

    // Remount with dirty sectors: no writeback, full reread.
    clear_logs();
    gcr(5'd0);
    gcr(5'd7);
    img_mounted = 1'b1;
    @(negedge clk32);
    img_mounted = 1'b0;
    @(negedge clk32);
    check("mnt_drop", ram_ready, 0);
    wait_ready("mnt");
    exp_reads(231, 21);
    cmp_log("mnt");
    check("mnt_loaded", loaded_track, 12);

    clear_logs();
    load("after_mnt", 6'd13);
    exp_reads(252, 21);
    cmp_log("after_mnt");

    check("rd_wr_exclusive", both_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
